// File: rtl/output_arbiter.sv
// Round-robin output-port arbiter for one mesh-router direction: picks one input
// per cycle, latches its flit into a single-entry output register, and pulses the winner's clear.
module output_arbiter #(
  parameter int         DATA_WIDTH = 64,
  parameter logic [4:0] DIRECTION  = 5'b10000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            reqL,
  input  logic [4:0]            reqR,
  input  logic [4:0]            reqU,
  input  logic [4:0]            reqD,
  input  logic [4:0]            reqPE,
  input  logic [DATA_WIDTH-1:0] dataL,
  input  logic [DATA_WIDTH-1:0] dataR,
  input  logic [DATA_WIDTH-1:0] dataU,
  input  logic [DATA_WIDTH-1:0] dataD,
  input  logic [DATA_WIDTH-1:0] dataPE,
  input  logic                  ro,
  output logic                  so,
  output logic [DATA_WIDTH-1:0] datao,
  output logic                  clrL,
  output logic                  clrR,
  output logic                  clrU,
  output logic                  clrD,
  output logic                  clrPE,
  output logic [4:0]            grant
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state, state_nxt;
  logic [2:0]            ptr, ptr_nxt;
  logic [DATA_WIDTH-1:0] datao_nxt;
  logic [4:0]            req_any, valid;
  logic [DATA_WIDTH-1:0] src_data [5];
  logic                  can_load, found;
  logic [2:0]            win, idx;
  logic [3:0]            sum;

  // Bit i of req_any/valid is source index i (L=0 .. PE=4); DIRECTION is MSB=L.
  assign req_any = {|reqPE, |reqD, |reqU, |reqR, |reqL};
  assign src_data[0] = dataL;
  assign src_data[1] = dataR;
  assign src_data[2] = dataU;
  assign src_data[3] = dataD;
  assign src_data[4] = dataPE;

  for (genvar i = 0; i < 5; i++) begin : g_valid
    assign valid[i] = req_any[i] & ~DIRECTION[4-i];
  end

  assign can_load = (state == EMPTY) || ro;
  assign so       = (state == FULL);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    datao_nxt = datao;
    grant     = 5'b0;
    found     = 1'b0;
    win       = 3'd0;
    idx       = 3'd0;
    sum       = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'd5) sum = sum - 4'd5;
      idx = sum[2:0];
      if (!found && valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    // Gate with rst so a reset never produces a clear pulse upstream.
    if (found && can_load && !rst) begin
      grant[3'd4 - win] = 1'b1;
      datao_nxt         = src_data[win];
      state_nxt         = FULL;
      ptr_nxt           = win;
    end else if (state == FULL && ro) begin
      state_nxt = EMPTY;
    end
  end

  assign clrL  = grant[4];
  assign clrR  = grant[3];
  assign clrU  = grant[2];
  assign clrD  = grant[1];
  assign clrPE = grant[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      ptr   <= 3'd4;
      datao <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      datao <= datao_nxt;
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: directed scenarios plus randomized
// traffic compared against a queue-free behavioural model of the arbitration rules.
module tb_output_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ro  = 1'b0;
  logic [4:0]  rq [5];
  logic [63:0] dt [5];

  logic        so, clrL, clrR, clrU, clrD, clrPE;
  logic [63:0] datao;
  logic [4:0]  grant;
  logic        so2, clrL2, clrR2, clrU2, clrD2, clrPE2;
  logic [63:0] datao2;
  logic [4:0]  grant2;

  int checks = 0;
  int failures = 0;

  // Behavioural model of the DIRECTION=10000 instance
  logic        m_full;
  logic [63:0] m_data;
  int          m_ptr;

  always #5 clk = ~clk;

  output_arbiter #(.DATA_WIDTH(64), .DIRECTION(5'b10000)) dut (
    .clk(clk), .rst(rst),
    .reqL(rq[0]), .reqR(rq[1]), .reqU(rq[2]), .reqD(rq[3]), .reqPE(rq[4]),
    .dataL(dt[0]), .dataR(dt[1]), .dataU(dt[2]), .dataD(dt[3]), .dataPE(dt[4]),
    .ro(ro), .so(so), .datao(datao),
    .clrL(clrL), .clrR(clrR), .clrU(clrU), .clrD(clrD), .clrPE(clrPE), .grant(grant)
  );

  // A PE-facing port, so L is a legal source after reset
  output_arbiter #(.DATA_WIDTH(64), .DIRECTION(5'b00001)) dut2 (
    .clk(clk), .rst(rst),
    .reqL(rq[0]), .reqR(rq[1]), .reqU(rq[2]), .reqD(rq[3]), .reqPE(rq[4]),
    .dataL(dt[0]), .dataR(dt[1]), .dataU(dt[2]), .dataD(dt[3]), .dataPE(dt[4]),
    .ro(ro), .so(so2), .datao(datao2),
    .clrL(clrL2), .clrR(clrR2), .clrU(clrU2), .clrD(clrD2), .clrPE(clrPE2), .grant(grant2)
  );

  function automatic int mwin();
    if (m_full && !ro) return -1;
    for (int k = 1; k <= 5; k++) begin
      int i = (m_ptr + k) % 5;
      if (rq[i] != 5'd0 && i != 0) return i;
    end
    return -1;
  endfunction

  function automatic logic [4:0] onehot(input int w);
    logic [4:0] top = 5'b10000;
    return (w < 0) ? 5'b0 : (top >> w);
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_data = 64'd0;
    m_ptr  = 4;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 5; i++) begin
      rq[i] = 5'd0;
      dt[i] = 64'd0;
    end
  endtask

  // Advance one edge and update the model with the winner chosen before it.
  task automatic tick();
    int w;
    w = mwin();
    @(posedge clk);
    if (w >= 0) begin
      m_full = 1'b1;
      m_data = dt[w];
      m_ptr  = w;
    end else if (m_full && ro) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    ro  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    ro = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (so !== 1'b0) begin failures++; $display("FAIL reset_so: got %b expected 0", so); end
      checks++;
      if (datao !== 64'd0) begin failures++; $display("FAIL reset_datao: got %h expected 0", datao); end
      checks++;
      if (grant !== 5'd0) begin failures++; $display("FAIL reset_grant: got %b expected 00000", grant); end
      checks++;
      if ({clrL, clrR, clrU, clrD, clrPE} !== 5'd0) begin
        failures++; $display("FAIL reset_clr: got %b expected 00000", {clrL, clrR, clrU, clrD, clrPE});
      end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    ro = 1'b1; rq[1] = 5'b01000; dt[1] = 64'hA5;
    #1;
    checks++;
    if (grant !== 5'b01000) begin failures++; $display("FAIL single_grant: got %b expected 01000", grant); end
    checks++;
    if (clrR !== 1'b1) begin failures++; $display("FAIL single_clrR: got %b expected 1", clrR); end
    tick();
    rq[1] = 5'd0;
    #1;
    checks++;
    if (so !== 1'b1 || datao !== 64'hA5) begin
      failures++; $display("FAIL single_out: got so=%b datao=%h expected so=1 datao=a5", so, datao);
    end
    tick();
    checks++;
    if (so !== 1'b0) begin failures++; $display("FAIL single_drain: got so=%b expected 0", so); end
  endtask

  task automatic test_round_robin();
    int seq [6] = '{1, 2, 4, 1, 2, 4};
    do_reset();
    ro = 1'b1;
    rq[1] = 5'b00001; rq[2] = 5'b00100; rq[4] = 5'b10000;
    for (int i = 0; i < 5; i++) dt[i] = 64'h1000 + 64'(i);
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (grant !== onehot(seq[c])) begin
        failures++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, grant, onehot(seq[c]));
      end
      checks++;
      if ({clrL, clrR, clrU, clrD, clrPE} !== onehot(seq[c])) begin
        failures++; $display("FAIL rr_clr[%0d]: got %b expected %b", c, {clrL, clrR, clrU, clrD, clrPE}, onehot(seq[c]));
      end
      if (c > 0) begin
        checks++;
        if (so !== 1'b1 || datao !== 64'h1000 + 64'(seq[c-1])) begin
          failures++; $display("FAIL rr_data[%0d]: got so=%b datao=%h expected %h", c, so, datao, 64'h1000 + 64'(seq[c-1]));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ro = 1'b1; rq[3] = 5'b00010; dt[3] = 64'hD0;
    tick();
    ro = 1'b0; dt[3] = 64'hD1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (so !== 1'b1 || datao !== 64'hD0 || clrD !== 1'b0 || grant !== 5'd0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got so=%b datao=%h clrD=%b grant=%b expected 1 d0 0 00000", c, so, datao, clrD, grant);
      end
      tick();
    end
    ro = 1'b1;
    #1;
    checks++;
    if (grant !== 5'b00010 || clrD !== 1'b1) begin
      failures++; $display("FAIL bp_release: got grant=%b clrD=%b expected 00010 1", grant, clrD);
    end
    tick();
    checks++;
    if (so !== 1'b1 || datao !== 64'hD1) begin
      failures++; $display("FAIL bp_data: got so=%b datao=%h expected 1 d1", so, datao);
    end
  endtask

  task automatic test_own_direction();
    do_reset();
    ro = 1'b1; rq[0] = 5'b10000; dt[0] = 64'hBAD;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (grant !== 5'd0 || clrL !== 1'b0 || so !== 1'b0) begin
        failures++; $display("FAIL own_dir[%0d]: got grant=%b clrL=%b so=%b expected 00000 0 0", c, grant, clrL, so);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ro = 1'b1; rq[1] = 5'b01000; dt[1] = 64'h77;
    tick();
    ro = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (so !== 1'b0 || datao !== 64'd0) begin
      failures++; $display("FAIL rstmid_out: got so=%b datao=%h expected 0 0", so, datao);
    end
    checks++;
    if (grant !== 5'd0 || clrR !== 1'b0 || grant2 !== 5'd0) begin
      failures++; $display("FAIL rstmid_clr: got grant=%b clrR=%b grant2=%b expected 0", grant, clrR, grant2);
    end
    #1;
    rst = 1'b0;
    model_reset();
    rq[1] = 5'd0;
    rq[0] = 5'b00001; dt[0] = 64'h11;
    rq[3] = 5'b00001; dt[3] = 64'h33;
    ro = 1'b1;
    #1;
    checks++;
    if (grant2 !== 5'b10000 || clrL2 !== 1'b1) begin
      failures++; $display("FAIL rstmid_pe_port: got grant2=%b clrL2=%b expected 10000 1", grant2, clrL2);
    end
    checks++;
    if (grant !== 5'b00010) begin
      failures++; $display("FAIL rstmid_l_port: got grant=%b expected 00010", grant);
    end
    tick();
    checks++;
    if (datao2 !== 64'h11 || datao !== 64'h33) begin
      failures++; $display("FAIL rstmid_data: got datao2=%h datao=%h expected 11 33", datao2, datao);
    end
  endtask

  task automatic test_random();
    int w;
    logic [4:0] eg;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 5; i++) begin
        rq[i] = ($urandom % 2 == 0) ? 5'($urandom) : 5'd0;
        dt[i] = {$urandom, $urandom};
      end
      ro = ($urandom % 4) != 0;
      #1;
      w  = mwin();
      eg = onehot(w);
      checks++;
      if (grant !== eg) begin failures++; $display("FAIL rand_grant[%0d]: got %b expected %b", c, grant, eg); end
      checks++;
      if ({clrL, clrR, clrU, clrD, clrPE} !== eg) begin
        failures++; $display("FAIL rand_clr[%0d]: got %b expected %b", c, {clrL, clrR, clrU, clrD, clrPE}, eg);
      end
      checks++;
      if (so !== m_full) begin failures++; $display("FAIL rand_so[%0d]: got %b expected %b", c, so, m_full); end
      if (m_full) begin
        checks++;
        if (datao !== m_data) begin failures++; $display("FAIL rand_datao[%0d]: got %h expected %h", c, datao, m_data); end
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_own_direction();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
